operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Operand-read stage between decode and the 32-entry register file (no internal forwarding).
//  Drives the regfile read addresses and captures operands, bypassing same-cycle writeback.
//  Keeps a 32-bit scoreboard of pending writers and stalls decode on RAW/WAW hazards.
//  Presents operands to execute over a valid/ready handshake; latency is 1 cycle.
// PARAMETERS
//  REG_WIDTH  64  width of register data (operands, regfile read data, writeback data)
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          decoded instruction valid
//  in_ready     out  1          stage accepts instruction this cycle
//  in_rs1       in   5          source register 1 index
//  in_rs2       in   5          source register 2 index
//  in_rd        in   5          destination register index
//  in_rd_we     in   1          instruction writes in_rd
//  rf_rs1       out  5          regfile read address 1 (= in_rs1, combinational)
//  rf_rs2       out  5          regfile read address 2 (= in_rs2, combinational)
//  rf_rs1_dout  in   REG_WIDTH  regfile read data 1 (combinational read)
//  rf_rs2_dout  in   REG_WIDTH  regfile read data 2
//  wb_valid     in   1          writeback this cycle (same write also drives the regfile)
//  wb_rd        in   5          writeback destination
//  wb_data      in   REG_WIDTH  writeback data
//  out_valid    out  1          operand bundle valid
//  out_ready    in   1          execute accepts bundle
//  out_rs1_val  out  REG_WIDTH  operand 1
//  out_rs2_val  out  REG_WIDTH  operand 2
//  out_rd       out  5          destination index, passed through
//  out_rd_we    out  1          destination write enable, passed through
//  busy_vec     out  32         scoreboard; bit i = write to xi pending
// BEHAVIOUR
//  Reset (async, rst_n=0): busy_vec=0, out_valid=0, out_rs1_val/out_rs2_val=0, out_rd=0, out_rd_we=0.
//  clr(r) = wb_valid && wb_rd==r && r!=0.  pend(r) = r!=0 && busy_vec[r] && !clr(r).
//  hazard = pend(in_rs1) || pend(in_rs2) || (in_rd_we && pend(in_rd)).
//  in_ready = (!out_valid || out_ready) && !hazard. It may depend on in_* and must not depend on in_valid.
//  accept = in_valid && in_ready. On accept, the output regs load and out_valid=1 on the next edge.
//  Operand select per source r, with priority: r==0 -> 0; clr(r) -> wb_data; else rf_*_dout.
//  If out_valid && out_ready && !accept, then out_valid=0. If !out_ready, the bundle holds stable.
//  Scoreboard, each edge: if clr(wb_rd), clear busy[wb_rd]. Then, if accept && in_rd_we && in_rd!=0,
//   set busy[in_rd]. Set wins when both hit the same index. busy[0] is never set.
//  A writeback to a non-busy register is legal. Its clear has no effect, and it still bypasses.
//  Back-to-back: dependent instruction stalls until its producer's wb_valid cycle. It is accepted
//   in that same cycle with wb_data bypassed. Throughput is 1 per cycle when there are no hazards.
//  Reset mid-operation discards any in-flight bundle and all pending scoreboard bits.
// TESTING
//  1 Reset: rst_n=0 mid-transfer -> out_valid=0, busy_vec=0 immediately, without waiting for clk.
//  2 rf x5=0x11, issue rs1=5,rs2=0,rd=6,we=1 -> next cycle out_rs1_val=0x11, out_rs2_val=0,
//    busy_vec=0x40.
//  3 x6 busy, issue rs1=6 -> in_ready=0. Then wb_valid,wb_rd=6,wb_data=0xAB -> accepted that cycle,
//    out_rs1_val=0xAB, busy[6] cleared.
//  4 wb_rd=7 and an accepted instruction with rd=7,we=1 in the same cycle -> busy[7]=1 afterwards.
//  5 out_ready=0 for 3 cycles with valid bundle -> in_ready=0, outputs stable. Then out_ready=1
//    with new input -> new bundle next cycle, no bubble.
//  6 rd=0,we=1 accepted -> busy_vec unchanged. wb_rd=0 with wb_data=0xFF -> a rs1=0 read gives 0.

Source files
------------

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode-side and execute-side handshake bundle for operand_fetch
interface operand_fetch_if #(
  parameter int REG_WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [4:0]           in_rd;
  logic                 in_rd_we;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] out_rs1_val;
  logic [REG_WIDTH-1:0] out_rs2_val;
  logic [4:0]           out_rd;
  logic                 out_rd_we;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
    input  in_ready, out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
    output in_ready, out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_we
  );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read stage with writeback bypass and RAW/WAW scoreboard
module operand_fetch #(
  parameter int REG_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_fetch_if.slave       bus,
  output logic [4:0]           rf_rs1_o,
  output logic [4:0]           rf_rs2_o,
  input  logic [REG_WIDTH-1:0] rf_rs1_dout_i,
  input  logic [REG_WIDTH-1:0] rf_rs2_dout_i,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_rd_i,
  input  logic [REG_WIDTH-1:0] wb_data_i,
  output logic [31:0]          busy_vec_o
);

  logic [31:0]          busy_q, busy_d, clr_vec;
  logic                 out_valid_q;
  logic [REG_WIDTH-1:0] rs1_val_q, rs2_val_q, rs1_val_d, rs2_val_d;
  logic [4:0]           rd_q;
  logic                 rd_we_q;
  logic                 pend_rs1, pend_rs2, pend_rd, hazard, accept;

  // x0 is never tracked, so a writeback to it clears nothing and bypasses nothing
  assign clr_vec = (wb_valid_i && (wb_rd_i != 5'd0)) ? (32'd1 << wb_rd_i) : 32'd0;

  assign pend_rs1 = (bus.in_rs1 != 5'd0) && busy_q[bus.in_rs1] && !clr_vec[bus.in_rs1];
  assign pend_rs2 = (bus.in_rs2 != 5'd0) && busy_q[bus.in_rs2] && !clr_vec[bus.in_rs2];
  assign pend_rd  = (bus.in_rd  != 5'd0) && busy_q[bus.in_rd]  && !clr_vec[bus.in_rd];
  assign hazard   = pend_rs1 || pend_rs2 || (bus.in_rd_we && pend_rd);

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  assign rf_rs1_o = bus.in_rs1;
  assign rf_rs2_o = bus.in_rs2;

  always_comb begin
    rs1_val_d = rf_rs1_dout_i;
    rs2_val_d = rf_rs2_dout_i;
    if (clr_vec[bus.in_rs1]) rs1_val_d = wb_data_i;
    if (clr_vec[bus.in_rs2]) rs2_val_d = wb_data_i;
    if (bus.in_rs1 == 5'd0)  rs1_val_d = '0;
    if (bus.in_rs2 == 5'd0)  rs2_val_d = '0;
  end

  // set after clear so a new writer wins over a same-cycle retiring one
  always_comb begin
    busy_d = busy_q & ~clr_vec;
    if (accept && bus.in_rd_we && (bus.in_rd != 5'd0)) busy_d[bus.in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        rs1_val_q   <= rs1_val_d;
        rs2_val_q   <= rs2_val_d;
        rd_q        <= bus.in_rd;
        rd_we_q     <= bus.in_rd_we;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_rs1_val = rs1_val_q;
  assign bus.out_rs2_val = rs2_val_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = rd_we_q;
  assign busy_vec_o      = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - randomized self-checking bench for operand_fetch
module tb_operand_fetch;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    rf_rs1, rf_rs2;
  logic [W-1:0]  rf_rs1_dout, rf_rs2_dout;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [W-1:0]  wb_data;
  logic [31:0]   busy_vec;
  logic [W-1:0]  rf [32];

  operand_fetch_if #(.REG_WIDTH(W)) bus ();

  operand_fetch #(.REG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2),
    .rf_rs1_dout_i(rf_rs1_dout), .rf_rs2_dout_i(rf_rs2_dout),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .busy_vec_o(busy_vec)
  );

  always #5 clk = ~clk;

  assign rf_rs1_dout = rf[rf_rs1];
  assign rf_rs2_dout = rf[rf_rs2];

  // reference model: set of pending writers plus the bundle execute should see
  bit           m_busy [32];
  bit           m_valid;
  logic [W-1:0] m_op1, m_op2;
  logic [4:0]   m_rd;
  bit           m_we;
  logic         last_ready;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_word();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit pending(input logic [4:0] r, input bit wv, input logic [4:0] wrd);
    return (r != 0) && m_busy[r] && !(wv && wrd == r);
  endfunction

  function automatic logic [W-1:0] operand(input logic [4:0] r, input bit wv,
                                           input logic [4:0] wrd, input logic [W-1:0] wd);
    if (r == 0) return '0;
    if (wv && wrd == r) return wd;
    return rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_valid = 1'b0;
  endtask

  // one cycle: called at a falling edge, returns at the next falling edge
  task automatic step(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input bit we, input bit ordy,
                      input bit wv, input logic [4:0] wrd, input logic [W-1:0] wd);
    bit exp_ready, acc;
    logic [W-1:0] o1, o2;
    bus.in_valid = iv; bus.in_rs1 = r1; bus.in_rs2 = r2; bus.in_rd = rd;
    bus.in_rd_we = we; bus.out_ready = ordy;
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    #1;
    exp_ready = (!m_valid || ordy) &&
                !(pending(r1, wv, wrd) || pending(r2, wv, wrd) || (we && pending(rd, wv, wrd)));
    last_ready = bus.in_ready;
    check("in_ready", bus.in_ready, exp_ready);
    check("rf_rs1", rf_rs1, r1);
    check("rf_rs2", rf_rs2, r2);
    acc = iv && exp_ready;
    o1 = operand(r1, wv, wrd, wd);
    o2 = operand(r2, wv, wrd, wd);
    @(posedge clk);
    #1;
    if (wv && wrd != 0) m_busy[wrd] = 1'b0;
    if (acc && we && rd != 0) m_busy[rd] = 1'b1;
    if (acc) begin
      m_valid = 1'b1; m_op1 = o1; m_op2 = o2; m_rd = rd; m_we = we;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (wv && wrd != 0) rf[wrd] = wd;
    @(negedge clk);
    check("out_valid", bus.out_valid, m_valid);
    check("busy_vec", busy_vec, model_busy_word());
    if (m_valid) begin
      check("out_rs1_val", bus.out_rs1_val, m_op1);
      check("out_rs2_val", bus.out_rs2_val, m_op2);
      check("out_rd", bus.out_rd, m_rd);
      check("out_rd_we", bus.out_rd_we, m_we);
    end
  endtask

  initial begin
    logic [4:0] cand [$];
    logic [4:0] r1, r2, rd, wrd;
    bit iv, we, ordy, wv;
    logic [W-1:0] wd;

    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.in_rd_we = 0; bus.out_ready = 1;
    wb_valid = 0; wb_rd = 0; wb_data = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_rs1_val", bus.out_rs1_val, 0);
    check("rst_rd_we", bus.out_rd_we, 0);
    rst_n = 1'b1;

    rf[5] = 64'h11;
    step(1, 5, 0, 6, 1, 1, 0, 0, '0);
    check("t2_op1", bus.out_rs1_val, 64'h11);
    check("t2_op2", bus.out_rs2_val, 0);
    check("t2_busy", busy_vec, 32'h40);

    step(1, 6, 0, 8, 0, 1, 0, 0, '0);
    check("t3_stall", last_ready, 0);
    step(1, 6, 0, 8, 0, 1, 1, 6, 64'hAB);
    check("t3_accept", last_ready, 1);
    check("t3_op1", bus.out_rs1_val, 64'hAB);
    check("t3_busy6", busy_vec[6], 0);

    step(1, 1, 2, 7, 1, 1, 1, 7, 64'h77);
    check("t4_busy7", busy_vec[7], 1);

    step(1, 1, 2, 0, 1, 1, 0, 0, '0);
    check("t6_busy", busy_vec, 32'h80);
    step(1, 0, 0, 3, 0, 1, 1, 0, 64'hFF);
    check("t6_zero", bus.out_rs1_val, 0);

    step(1, 1, 2, 3, 0, 1, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1, 4, 4, 3, 0, 0, 0, 0, '0);
      check("t5_stall", last_ready, 0);
      check("t5_hold", bus.out_rs1_val, rf[1]);
    end
    step(1, 4, 5, 9, 1, 1, 0, 0, '0);
    check("t5_accept", last_ready, 1);
    check("t5_new", bus.out_rs1_val, rf[4]);
    check("t5_valid", bus.out_valid, 1);

    step(1, 1, 1, 1, 0, 0, 0, 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_out_valid", bus.out_valid, 0);
    check("t1_busy", busy_vec, 0);
    check("t1_rs1_val", bus.out_rs1_val, 0);
    check("t1_rd", bus.out_rd, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      r1   = 5'($urandom_range(0, 7));
      r2   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      we   = $urandom_range(0, 3) != 0;
      iv   = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      wv   = $urandom_range(0, 2) == 0;
      cand.delete();
      for (int j = 1; j < 8; j++) if (m_busy[j]) cand.push_back(5'(j));
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        wrd = cand[$urandom_range(0, cand.size() - 1)];
      else
        wrd = 5'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      step(iv, r1, r2, rd, we, ordy, wv, wrd, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
